core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter: INSTRET_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  opcode field from the instruction decoder; 7'b0 denotes a compressed/ignored instruction.
REQ-005 imem_ack  input  1  instruction memory has returned the word; valid only while imem_req=1.
REQ-006 dmem_ack  input  1  data access complete; valid only while dmem_req=1.
REQ-007 branch_taken  input  1  ALU compare result, sampled in EXECUTE for BRANCH.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 dmem_req  output  1  data memory request.
REQ-010 dmem_we  output  1  data write enable; qualifies dmem_req.
REQ-011 ir_we  output  1  instruction-register load strobe.
REQ-012 reg_we  output  1  register-file write strobe.
REQ-013 pc_we  output  1  PC update strobe.
REQ-014 pc_sel  output  1  1 = PC loads target, 0 = PC loads PC+4.
REQ-015 retire  output  1  one-cycle pulse per completed instruction.
REQ-016 trap  output  1  illegal-instruction trap flag.
REQ-017 state  output  3  current FSM state encoding.
REQ-018 instret  output  INSTRET_W  count of retired instructions.

Function
REQ-019 States/encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to FETCH next cycle.
REQ-020 All strobes (imem_req..retire) SHALL be combinational decodes of the registered state plus inputs, and SHALL be forced to 0 while rst=1.
REQ-021 FETCH: imem_req=1 until imem_ack; on ack, ir_we=1 for that cycle and next state is DECODE; otherwise remain in FETCH.
REQ-022 DECODE: one cycle; legal opcode -> EXECUTE; illegal opcode -> behaviour per REQ-033/034.
REQ-023 Legal opcodes: 0110111, 0010111, 1101111, 1100111, 0000011, 0100011, 1100011, 0010011, 0110011; all others, including 7'b0, are illegal.
REQ-024 EXECUTE: LOAD/STORE -> MEM; BRANCH -> pc_we=1, pc_sel=branch_taken, retire=1, next FETCH; all other legal opcodes -> WB.
REQ-025 MEM: dmem_req=1 and dmem_we=(opcode==STORE) held until dmem_ack; on ack, LOAD -> WB; STORE -> pc_we=1, pc_sel=0, retire=1, next FETCH.
REQ-026 WB: reg_we=1, pc_we=1, retire=1, pc_sel=1 for JAL/JALR else 0; next FETCH.
REQ-027 Requests SHALL NOT be retracted before ack; an ack arriving while the matching req=0 SHALL be ignored.
REQ-028 Latency with zero-wait memory (ack same cycle as req): BRANCH 3 cycles, ALU/LUI/AUIPC/JAL/JALR 4 cycles, STORE 4 cycles, LOAD 5 cycles.
REQ-029 instret SHALL increment by 1 on every cycle retire=1 and wrap from all-ones to 0.
REQ-030 opcode SHALL be sampled combinationally each cycle; it is held stable by the instruction register from DECODE through retirement.

Reset
REQ-031 On rst=1 at a clock edge: state<=FETCH, instret<=0, trap<=0, regardless of current state, including mid-MEM or mid-FETCH with requests outstanding.
REQ-032 The first cycle after rst deasserts SHALL be FETCH with imem_req=1.

Configuration
REQ-033 With ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> TRAP; in TRAP all strobes are 0, trap=1, and the state holds until rst.
REQ-034 Without ILLEGAL_TRAP_EN: illegal opcode in DECODE is a NOP, giving pc_we=1, pc_sel=0, retire=1 and next FETCH; trap is tied to 0 and TRAP is unreachable.

Verification
REQ-035 Reset, then opcode=0010011 with imem_ack/dmem_ack tied 1 -> states 0,1,2,4,0; reg_we and retire high in cycle 4; instret=1.
REQ-036 LOAD (0000011) with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then WB; instret+1.
REQ-037 BRANCH (1100011) with branch_taken=1 -> pc_we=1, pc_sel=1 in EXECUTE, no reg_we; retire cycle 3.
REQ-038 opcode=7'b0: ILLEGAL_TRAP_EN defined -> state=5, trap=1 held for 10 cycles, then rst clears it; undefined -> pc_we=1, pc_sel=0, retire=1, back to FETCH.
REQ-039 rst asserted during MEM with dmem_req=1 -> next cycle dmem_req=0, state=0, instret=0.
REQ-040 INSTRET_W=4, retire 17 ALU instructions -> instret wraps 15->0 and reads 1.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB control FSM with retired-instruction counter.
// Latency (zero-wait memory): BRANCH 3, ALU/LUI/AUIPC/JAL/JALR/STORE 4, LOAD 5 cycles; strobes are combinational from state.
// Backpressure: imem_req/dmem_req held until the matching ack; acks seen while the request is low are ignored.
// Optional feature: define ILLEGAL_TRAP_EN to trap on illegal opcodes (otherwise they retire as NOPs).
module core_sequencer #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  input  logic                 branch_taken,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_we,
  output logic                 reg_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 retire,
  output logic                 trap,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  state_t state_q;
  state_t state_nxt;
  logic   legal;

  assign state = state_q;

  // Opcode legality decode; 7'b0 (compressed/ignored) falls into the illegal set.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
      OP_STORE, OP_BRANCH, OP_IMM, OP_REG: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
  end

  // Next-state and strobe decode from the registered state; every strobe is squashed during reset.
  always_comb begin
    state_nxt = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_nxt = S_EXECUTE;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_nxt = S_TRAP;
`else
          pc_we     = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
`endif
        end
      end
      S_EXECUTE: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_nxt = S_MEM;
        end else if (opcode == OP_BRANCH) begin
          pc_we     = 1'b1;
          pc_sel    = branch_taken;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ack) begin
          if (opcode == OP_STORE) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        pc_sel    = (opcode == OP_JAL || opcode == OP_JALR);
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:  state_nxt = S_TRAP;
`endif
      default: state_nxt = S_FETCH;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      reg_we   = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      retire   = 1'b0;
    end
  end

  // State register and retired-instruction counter (wraps naturally at all-ones).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      instret <= '0;
    end else begin
      state_q <= state_nxt;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic trap_q;

  // Trap flag tracks residence in TRAP; only reset leaves that state.
  always_ff @(posedge clk) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= (state_nxt == S_TRAP);
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle state/strobe checks for each instruction class,
// reset behaviour, illegal-opcode handling, and instret wrap on a 4-bit counter instance.
// Inputs change and outputs are sampled just after the falling edge.
module tb_core_sequencer;

  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        branch_taken = 1'b0;

  logic        imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we, pc_sel, retire, trap;
  logic [2:0]  state;
  logic [31:0] instret;

  logic        imem_req4, dmem_req4, dmem_we4, ir_we4, reg_we4, pc_we4, pc_sel4, retire4, trap4;
  logic [2:0]  state4;
  logic [3:0]  instret4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  core_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire),
    .trap(trap), .state(state), .instret(instret)
  );

  core_sequencer #(.INSTRET_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .imem_req(imem_req4), .dmem_req(dmem_req4), .dmem_we(dmem_we4),
    .ir_we(ir_we4), .reg_we(reg_we4), .pc_we(pc_we4), .pc_sel(pc_sel4), .retire(retire4),
    .trap(trap4), .state(state4), .instret(instret4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive(input logic [6:0] op, input logic ia, input logic da, input logic bt);
    @(negedge clk);
    opcode = op; imem_ack = ia; dmem_ack = da; branch_taken = bt;
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    #1;
    chk("rst_imem_req_forced0", imem_req, 0);
    chk("rst_retire_forced0", retire, 0);
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    chk("post_rst_state", state, 0);
    chk("post_rst_imem_req", imem_req, 1);
    chk("post_rst_instret", instret, 0);
    chk("post_rst_trap", trap, 0);
  endtask

  initial begin
    int req_cycles;

    // ALU immediate, zero-wait memory
    do_reset();
    drive(OP_I, 1, 1, 0);
    chk("alu_c1_state", state, 0);
    chk("alu_c1_ir_we", ir_we, 1);
    drive(OP_I, 1, 1, 0);
    chk("alu_c2_state", state, 1);
    chk("alu_c2_imem_req", imem_req, 0);
    drive(OP_I, 1, 1, 0);
    chk("alu_c3_state", state, 2);
    drive(OP_I, 1, 1, 0);
    chk("alu_c4_state", state, 4);
    chk("alu_c4_reg_we", reg_we, 1);
    chk("alu_c4_retire", retire, 1);
    chk("alu_c4_pc_sel", pc_sel, 0);
    drive(OP_I, 0, 0, 0);
    chk("alu_c5_state", state, 0);
    chk("alu_instret", instret, 1);

    // LOAD with stray dmem_ack in FETCH and a 3-cycle data delay
    do_reset();
    drive(OP_LD, 0, 1, 0);
    chk("ld_stray_ack_state", state, 0);
    chk("ld_stray_ack_ir_we", ir_we, 0);
    drive(OP_LD, 1, 0, 0);
    chk("ld_fetch_ir_we", ir_we, 1);
    drive(OP_LD, 0, 0, 0);
    chk("ld_decode_state", state, 1);
    drive(OP_LD, 0, 0, 0);
    chk("ld_exec_state", state, 2);
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      drive(OP_LD, 0, (i == 3), 0);
      chk("ld_mem_state", state, 3);
      chk("ld_mem_we", dmem_we, 0);
      if (dmem_req) req_cycles++;
    end
    chk("ld_dmem_req_cycles", req_cycles, 4);
    drive(OP_LD, 0, 0, 0);
    chk("ld_wb_state", state, 4);
    chk("ld_wb_reg_we", reg_we, 1);
    drive(OP_LD, 0, 0, 0);
    chk("ld_instret", instret, 1);

    // BRANCH taken, then not taken
    do_reset();
    drive(OP_BR, 1, 1, 1);
    drive(OP_BR, 1, 1, 1);
    chk("br_t_decode", state, 1);
    drive(OP_BR, 1, 1, 1);
    chk("br_t_exec_state", state, 2);
    chk("br_t_pc_we", pc_we, 1);
    chk("br_t_pc_sel", pc_sel, 1);
    chk("br_t_reg_we", reg_we, 0);
    chk("br_t_retire", retire, 1);
    drive(OP_BR, 1, 1, 0);
    chk("br_t_back_fetch", state, 0);
    chk("br_t_instret", instret, 1);
    drive(OP_BR, 1, 1, 0);
    drive(OP_BR, 1, 1, 0);
    chk("br_n_pc_sel", pc_sel, 0);
    chk("br_n_retire", retire, 1);
    drive(OP_BR, 0, 0, 0);
    chk("br_n_instret", instret, 2);

    // STORE, zero-wait
    do_reset();
    drive(OP_ST, 1, 1, 0);
    drive(OP_ST, 1, 1, 0);
    drive(OP_ST, 1, 1, 0);
    drive(OP_ST, 1, 1, 0);
    chk("st_mem_state", state, 3);
    chk("st_dmem_req", dmem_req, 1);
    chk("st_dmem_we", dmem_we, 1);
    chk("st_pc_we", pc_we, 1);
    chk("st_pc_sel", pc_sel, 0);
    chk("st_retire", retire, 1);
    chk("st_reg_we", reg_we, 0);
    drive(OP_ST, 0, 0, 0);
    chk("st_back_fetch", state, 0);
    chk("st_instret", instret, 1);

    // JAL writes back with pc_sel=1
    do_reset();
    drive(OP_JAL, 1, 1, 0);
    drive(OP_JAL, 1, 1, 0);
    drive(OP_JAL, 1, 1, 0);
    drive(OP_JAL, 1, 1, 0);
    chk("jal_wb_state", state, 4);
    chk("jal_pc_sel", pc_sel, 1);
    chk("jal_reg_we", reg_we, 1);

    // Illegal opcode 7'b0
    do_reset();
    drive(OP_BAD, 1, 1, 0);
    drive(OP_BAD, 0, 0, 0);
    chk("bad_decode_state", state, 1);
`ifdef ILLEGAL_TRAP_EN
    chk("bad_decode_retire", retire, 0);
    for (int i = 0; i < 10; i++) begin
      drive(OP_BAD, 1, 1, 0);
      chk("trap_state", state, 5);
      chk("trap_flag", trap, 1);
      chk("trap_imem_req", imem_req, 0);
    end
    do_reset();
    chk("trap_cleared", trap, 0);
`else
    chk("bad_pc_we", pc_we, 1);
    chk("bad_pc_sel", pc_sel, 0);
    chk("bad_retire", retire, 1);
    drive(OP_BAD, 0, 0, 0);
    chk("bad_back_fetch", state, 0);
    chk("bad_instret", instret, 1);
    chk("bad_trap", trap, 0);
`endif

    // Reset while a data request is outstanding
    do_reset();
    for (int i = 0; i < 4; i++) drive(OP_I, 1, 1, 0);
    drive(OP_LD, 1, 0, 0);
    chk("mr_instret_before", instret, 1);
    drive(OP_LD, 0, 0, 0);
    drive(OP_LD, 0, 0, 0);
    drive(OP_LD, 0, 0, 0);
    chk("mr_in_mem", state, 3);
    chk("mr_dmem_req", dmem_req, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_req_forced0", dmem_req, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_state", state, 0);
    chk("mr_dmem_req_after", dmem_req, 0);
    chk("mr_instret", instret, 0);

    // 17 ALU retirements: 4-bit counter wraps to 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(OP_I, 1, 1, 0);
      if (i == 16) chk("wrap_at16", instret4, 0);
      drive(OP_I, 1, 1, 0);
      drive(OP_I, 1, 1, 0);
      drive(OP_I, 1, 1, 0);
    end
    drive(OP_I, 0, 0, 0);
    chk("wrap_instret4", instret4, 1);
    chk("wrap_instret32", instret, 17);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
